fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 12, the ROM word-address width.
REQ-003 Parameter TIMEOUT, default 15, the maximum number of wait cycles for rom_ready before a fault is raised (range 1..255).
REQ-004 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 stall  input  1  downstream cannot accept the held instruction.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 rom_req  output  1  ROM read request.
REQ-010 rom_addr  output  ADDR_W  ROM word address, equal to pc[ADDR_W+1:2].
REQ-011 rom_ready  input  1  ROM read data is valid this cycle.
REQ-012 rom_rdata  input  32  ROM read data.
REQ-013 instr_valid  output  1  instr and instr_pc are valid.
REQ-014 instr  output  32  fetched instruction.
REQ-015 instr_pc  output  32  byte address of instr.
REQ-016 pc  output  32  current fetch PC.
REQ-017 fault  output  1  misaligned redirect or ROM timeout; sticky.

Function
REQ-018 The controller SHALL implement the states IDLE, FETCH, DELIVER and FAULT.
REQ-019 IDLE SHALL go to FETCH unconditionally on the first clock edge after rst is released.
REQ-020 In FETCH, rom_req SHALL be 1, and rom_addr SHALL be held stable until rom_ready is sampled 1.
REQ-021 When rom_ready is 1 in FETCH, the controller SHALL latch instr<=rom_rdata and instr_pc<=pc, set instr_valid<=1, and go to DELIVER.
REQ-022 In DELIVER, rom_req SHALL be 0, and instr, instr_pc and instr_valid SHALL hold while stall is 1.
REQ-023 When stall is 0 in DELIVER, the controller SHALL set pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), set instr_valid<=0, and go to FETCH.
REQ-024 Throughput SHALL be one instruction per two cycles when rom_ready is tied to 1 and stall is 0.
REQ-025 A wait counter SHALL clear on entry to FETCH and increment on each FETCH cycle in which rom_ready is 0.
REQ-026 When the wait counter reaches TIMEOUT, the controller SHALL set fault<=1 and go to FAULT.
REQ-027 An aligned redirect (redirect_valid=1 and redirect_pc[1:0]=0), in any non-IDLE state, SHALL set pc<=redirect_pc, set instr_valid<=0, clear the wait counter and go to FETCH.
REQ-028 Redirect SHALL take priority over rom_ready, stall and timeout arriving in the same cycle; ROM data arriving in that cycle SHALL be discarded.
REQ-029 A misaligned redirect (redirect_pc[1:0]!=0) SHALL set fault<=1, set instr_valid<=0, leave pc unchanged and go to FAULT.
REQ-030 In FAULT, rom_req SHALL be 0 and instr_valid SHALL be 0.
REQ-031 FAULT SHALL be left only by an aligned redirect, which goes to FETCH and clears fault.
REQ-032 redirect_valid SHALL be ignored in IDLE.
REQ-033 rom_req SHALL never be 1 outside FETCH.
REQ-034 At most one ROM request SHALL be outstanding at any time.

Reset
REQ-035 While rst=0, the outputs SHALL immediately take: pc=RESET_PC, rom_req=0, instr_valid=0, instr=0, instr_pc=0, fault=0; the state SHALL be IDLE and the wait counter 0.
REQ-036 Reset asserted mid-fetch SHALL abandon the pending request with no residual instr_valid.

Verification
REQ-037 Release rst with rom_ready=1, stall=0, ROM[i]=i -> rom_req high on cycle 2; instr_valid pulses with instr_pc=0,4,8 and instr=0,1,2 on alternating cycles.
REQ-038 Assert stall for 3 cycles while instr_valid=1 -> instr/instr_pc stay constant, rom_req=0, and pc does not advance until stall drops.
REQ-039 redirect_valid=1, redirect_pc=32'h0000_0100, in the same cycle as rom_ready=1 -> data discarded; next rom_addr=12'h040 and next instr_pc=32'h100.
REQ-040 rom_ready held 0 with TIMEOUT=15 -> fault=1 after 15 wait cycles and rom_req=0; then an aligned redirect to 0 -> fault=0 and fetch resumes.
REQ-041 redirect_pc=32'h0000_0102 -> fault=1, pc unchanged, instr_valid=0.
REQ-042 Assert rst=0 asynchronously between clock edges while in FETCH -> outputs reach reset values before the next edge; pc=RESET_PC.
REQ-043 Redirect to 32'hFFFF_FFFC, then complete one fetch -> pc wraps to 32'h0000_0000.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a word-addressed ROM one instruction
// at a time. It presents each instruction until downstream accepts it, follows
// branch/jump redirects and raises a sticky fault on a misaligned redirect or
// when the ROM does not answer within TIMEOUT wait cycles.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ready,
  input  logic [31:0]       rom_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic [31:0]       pc,
  output logic              fault
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DELIVER,
    FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  state_t      state_d;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [31:0] instr_pc_d;
  logic        instr_valid_d;
  logic        fault_d;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_d;
  logic [7:0]  wait_cnt_inc;
  logic        redirect_aligned;

  // The request is a pure function of the state, so only one can ever be open.
  assign rom_req          = (state == FETCH);
  assign rom_addr         = pc[ADDR_W+1:2];
  assign wait_cnt_inc     = wait_cnt + 8'd1;
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // Next-state and next-register values; a redirect overrides everything else.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = instr_valid;
    fault_d       = fault;
    wait_cnt_d    = wait_cnt;

    case (state)
      IDLE: begin
        state_d    = FETCH;
        wait_cnt_d = 8'd0;
      end
      FETCH: begin
        if (rom_ready) begin
          instr_d       = rom_rdata;
          instr_pc_d    = pc;
          instr_valid_d = 1'b1;
          state_d       = DELIVER;
        end else if (wait_cnt_inc == TIMEOUT_CNT) begin
          wait_cnt_d = wait_cnt_inc;
          fault_d    = 1'b1;
          state_d    = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      DELIVER: begin
        if (!stall) begin
          pc_d          = pc + 32'd4;
          instr_valid_d = 1'b0;
          wait_cnt_d    = 8'd0;
          state_d       = FETCH;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state != IDLE) && redirect_valid) begin
      instr_d       = instr;
      instr_pc_d    = instr_pc;
      instr_valid_d = 1'b0;
      if (redirect_aligned) begin
        pc_d       = redirect_pc;
        wait_cnt_d = 8'd0;
        fault_d    = 1'b0;
        state_d    = FETCH;
      end else begin
        pc_d       = pc;
        wait_cnt_d = wait_cnt;
        fault_d    = 1'b1;
        state_d    = FAULT;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
      fault       <= fault_d;
      wait_cnt    <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller. The ROM returns its own word
// address as data; expected deliveries go into a scoreboard queue and are
// compared by a monitor on each rising edge of instr_valid.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ADDR_W   = 12;
  localparam int          TIMEOUT  = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'd0;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ready = 1'b0;
  logic [31:0]       rom_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic [31:0]       pc;
  logic              fault;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;
  logic        valid_prev = 1'b0;

  fetch_controller #(
    .RESET_PC(RESET_PC),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_req       (rom_req),
    .rom_addr      (rom_addr),
    .rom_ready     (rom_ready),
    .rom_rdata     (rom_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc            (pc),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  // ROM model: word i holds the value i.
  assign rom_rdata = {20'd0, rom_addr};

  // Monitor: compare each new delivery against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      valid_prev = 1'b0;
    end else begin
      checks++;
      if (rom_req && instr_valid) begin
        failures++;
        $display("[TB] FAIL req_valid_overlap: rom_req=%0b instr_valid=%0b, required not both 1", rom_req, instr_valid);
      end
      if (instr_valid && !valid_prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_delivery: instr_pc=%h instr=%h, required none", instr_pc, instr);
        end else begin
          mon_exp = sb.pop_front();
          if ({instr_pc, instr} !== mon_exp) begin
            failures++;
            $display("[TB] FAIL delivery: instr_pc=%h instr=%h, required instr_pc=%h instr=%h", instr_pc, instr, mon_exp[63:32], mon_exp[31:0]);
          end
        end
      end
      valid_prev = instr_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    rom_ready = 1'b0;
    tick();
    tick();
    sb.delete();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain: pending=%0d, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pc, instr, instr_pc} !== {RESET_PC, 32'd0, 32'd0}) begin
      failures++;
      $display("[TB] FAIL reset_regs: pc=%h instr=%h instr_pc=%h, required %h 0 0", pc, instr, instr_pc, RESET_PC);
    end
    checks++;
    if ({rom_req, instr_valid, fault} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: req=%0b valid=%0b fault=%0b, required 0 0 0", rom_req, instr_valid, fault);
    end
    tick();
    checks++;
    if ({rom_req, instr_valid, pc} !== {2'b00, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL reset_hold: req=%0b valid=%0b pc=%h, required 0 0 %h", rom_req, instr_valid, pc, RESET_PC);
    end
  endtask

  task automatic test_basic();
    do_reset();
    rom_ready = 1'b1;
    sb.push_back({32'h0, 32'h0});
    sb.push_back({32'h4, 32'h1});
    sb.push_back({32'h8, 32'h2});
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if ({instr_valid, rom_req} !== {(k % 2 == 0), (k % 2 == 1)}) begin
        failures++;
        $display("[TB] FAIL basic_cycle%0d: valid=%0b req=%0b, required %0b %0b", k, instr_valid, rom_req, (k % 2 == 0), (k % 2 == 1));
      end
    end
    wait_drain("basic");
    rom_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    rom_ready = 1'b1;
    stall = 1'b1;
    sb.push_back({32'h0, 32'h0});
    sb.push_back({32'h4, 32'h1});
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({instr_valid, rom_req, instr, instr_pc, pc} !== {2'b10, 32'h0, 32'h0, 32'h0}) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d: valid=%0b req=%0b instr=%h instr_pc=%h pc=%h, required 1 0 0 0 0", k, instr_valid, rom_req, instr, instr_pc, pc);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({instr_valid, rom_req, pc} !== {2'b01, 32'h4}) begin
      failures++;
      $display("[TB] FAIL stall_release: valid=%0b req=%0b pc=%h, required 0 1 00000004", instr_valid, rom_req, pc);
    end
    wait_drain("stall");
    rom_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    rst = 1'b1;
    tick();
    checks++;
    if ({pc, rom_req} !== {RESET_PC, 1'b1}) begin
      failures++;
      $display("[TB] FAIL redirect_idle_ignored: pc=%h req=%0b, required %h 1", pc, rom_req, RESET_PC);
    end
    redirect_pc = 32'h0000_0100;
    rom_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({rom_addr, pc, instr_valid, rom_req} !== {12'h040, 32'h100, 2'b01}) begin
      failures++;
      $display("[TB] FAIL redirect_target: addr=%h pc=%h valid=%0b req=%0b, required 040 00000100 0 1", rom_addr, pc, instr_valid, rom_req);
    end
    sb.push_back({32'h100, 32'h40});
    wait_drain("redirect");
    rom_ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    rst = 1'b1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      checks++;
      if ({fault, rom_req} !== 2'b01) begin
        failures++;
        $display("[TB] FAIL timeout_wait%0d: fault=%0b req=%0b, required 0 1", k, fault, rom_req);
      end
    end
    tick();
    checks++;
    if ({fault, rom_req, instr_valid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL timeout_fault: fault=%0b req=%0b valid=%0b, required 1 0 0", fault, rom_req, instr_valid);
    end
    rom_ready = 1'b1;
    tick();
    checks++;
    if ({fault, rom_req} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL timeout_sticky: fault=%0b req=%0b, required 1 0", fault, rom_req);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({fault, rom_req, pc} !== {2'b01, 32'h0}) begin
      failures++;
      $display("[TB] FAIL timeout_recover: fault=%0b req=%0b pc=%h, required 0 1 00000000", fault, rom_req, pc);
    end
    sb.push_back({32'h0, 32'h0});
    wait_drain("timeout");
    rom_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    rom_ready = 1'b1;
    stall = 1'b1;
    sb.push_back({32'h0, 32'h0});
    rst = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({fault, instr_valid, rom_req, pc} !== {3'b100, 32'h0}) begin
      failures++;
      $display("[TB] FAIL misaligned: fault=%0b valid=%0b req=%0b pc=%h, required 1 0 0 00000000", fault, instr_valid, rom_req, pc);
    end
    stall = 1'b0;
    tick();
    tick();
    checks++;
    if ({fault, rom_req, instr_valid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL misaligned_stay: fault=%0b req=%0b valid=%0b, required 1 0 0", fault, rom_req, instr_valid);
    end
    wait_drain("misaligned");
    rom_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    rst = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({pc, rom_req} !== {32'h20, 1'b1}) begin
      failures++;
      $display("[TB] FAIL async_setup: pc=%h req=%0b, required 00000020 1", pc, rom_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pc, rom_addr, rom_req, instr_valid, fault} !== {RESET_PC, 12'h000, 3'b000}) begin
      failures++;
      $display("[TB] FAIL async_reset: pc=%h addr=%h req=%0b valid=%0b fault=%0b, required %h 000 0 0 0", pc, rom_addr, rom_req, instr_valid, fault, RESET_PC);
    end
    rom_ready = 1'b1;
    tick();
    tick();
    rom_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({instr_valid, rom_req, pc} !== {2'b01, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL async_no_residue: valid=%0b req=%0b pc=%h, required 0 1 %h", instr_valid, rom_req, pc, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rst = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    rom_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({pc, rom_addr} !== {32'hFFFF_FFFC, 12'hFFF}) begin
      failures++;
      $display("[TB] FAIL wrap_target: pc=%h addr=%h, required fffffffc fff", pc, rom_addr);
    end
    sb.push_back({32'hFFFF_FFFC, 32'h0000_0FFF});
    tick();
    tick();
    rom_ready = 1'b0;
    checks++;
    if ({pc, rom_addr} !== {32'h0, 12'h000}) begin
      failures++;
      $display("[TB] FAIL wrap_pc: pc=%h addr=%h, required 00000000 000", pc, rom_addr);
    end
    wait_drain("wrap");
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_timeout();
    test_misaligned();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
